// File: rtl/debug_view_port.sv
// debug_view_port: reads data-RAM words for the board display in RAM cycles the CPU leaves idle.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   view_en, view_addr   view request and word index from the board top
//   data_high/data_low   viewed word halves, data_valid when they match the latched address
//   cpu_stall            one-cycle stall request when the view has to force a RAM slot
//   cpu_*                CPU side of the data-RAM port (cpu_rdata mirrors ram_rdata)
//   ram_*                single-port data RAM, synchronous read with one cycle of latency
module debug_view_port #(
    parameter int unsigned REFRESH_CYCLES = 1000000,
    parameter int unsigned STARVE_LIMIT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        view_en,
    input  logic [31:0] view_addr,
    output logic [15:0] data_high,
    output logic [15:0] data_low,
    output logic        data_valid,
    output logic        cpu_stall,
    input  logic        cpu_ce,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [3:0]  cpu_sel,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 2);
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
    localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, WAIT_SLOT, CAPTURE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [RW-1:0] refresh_q, refresh_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [15:0]   data_high_q, data_high_d;
    logic [15:0]   data_low_q, data_low_d;
    logic          valid_q, valid_d;
    logic          addr_match, refresh_wrap, grant;

    assign addr_match   = view_addr == addr_q;
    assign refresh_wrap = refresh_q == REFRESH_LAST;
    // A pending address change wins over the grant so the word read always matches addr_q.
    assign grant        = view_en && state_q == WAIT_SLOT && addr_match &&
                          (!cpu_ce || starve_q == STARVE_MAX);
    assign cpu_stall    = grant && cpu_ce;

    assign ram_ce    = grant | cpu_ce;
    assign ram_we    = grant ? 1'b0 : cpu_we;
    assign ram_sel   = grant ? 4'hF : cpu_sel;
    assign ram_addr  = grant ? {addr_q[29:0], 2'b00} : cpu_addr;
    assign ram_wdata = grant ? 32'h0 : cpu_wdata;
    assign cpu_rdata = ram_rdata;

    assign data_high  = data_high_q;
    assign data_low   = data_low_q;
    assign data_valid = valid_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        refresh_d   = refresh_q;
        starve_d    = starve_q;
        data_high_d = data_high_q;
        data_low_d  = data_low_q;
        valid_d     = valid_q;
        if (!view_en) begin
            state_d     = IDLE;
            addr_d      = '0;
            refresh_d   = '0;
            starve_d    = '0;
            data_high_d = '0;
            data_low_d  = '0;
            valid_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    refresh_d = refresh_wrap ? '0 : refresh_q + RW'(1);
                    if (!addr_match) begin
                        addr_d  = view_addr;
                        valid_d = 1'b0;
                    end
                    if (!addr_match || !valid_q || refresh_wrap)
                        state_d = WAIT_SLOT;
                end
                WAIT_SLOT: begin
                    if (!addr_match) begin
                        addr_d  = view_addr;
                        valid_d = 1'b0;
                    end else if (grant) begin
                        state_d  = CAPTURE;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_q + SW'(1);
                    end
                end
                CAPTURE: begin
                    if (addr_match) begin
                        data_high_d = ram_rdata[31:16];
                        data_low_d  = ram_rdata[15:0];
                        valid_d     = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        // Word belongs to a stale address: drop it and fetch again.
                        addr_d  = view_addr;
                        valid_d = 1'b0;
                        state_d = WAIT_SLOT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            refresh_q   <= '0;
            starve_q    <= '0;
            data_high_q <= '0;
            data_low_q  <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            refresh_q   <= refresh_d;
            starve_q    <= starve_d;
            data_high_q <= data_high_d;
            data_low_q  <= data_low_d;
            valid_q     <= valid_d;
        end
    end
endmodule

// File: tb/tb_debug_view_port.sv
// tb_debug_view_port: directed checks of debug_view_port against a bench-side synchronous RAM.
module tb_debug_view_port;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        view_en = 1'b0;
    logic [31:0] view_addr = '0;
    logic [15:0] data_high, data_low;
    logic        data_valid, cpu_stall;
    logic        cpu_ce = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [3:0]  cpu_sel = 4'hF;
    logic [31:0] cpu_rdata;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_sel;
    logic [31:0] ram_rdata = '0;
    logic [31:0] mem [0:255];
    int errors = 0;
    int checks = 0;
    int stalls, first_stall, n;

    debug_view_port #(.REFRESH_CYCLES(8), .STARVE_LIMIT(16)) dut (
        .clk(clk), .rst(rst), .view_en(view_en), .view_addr(view_addr),
        .data_high(data_high), .data_low(data_low), .data_valid(data_valid),
        .cpu_stall(cpu_stall), .cpu_ce(cpu_ce), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_sel(cpu_sel), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_ce) begin
            ram_rdata <= mem[ram_addr[9:2]];
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic restart(input logic [31:0] a, input logic ce);
        view_en = 1'b0;
        cpu_ce  = 1'b0;
        step();
        view_en   = 1'b1;
        view_addr = a;
        cpu_ce    = ce;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h1234ABCD;
        mem[8'h20] = 32'hCAFEF00D;
        #12;
        check("rst_high", data_high, 0);
        check("rst_low", data_low, 0);
        check("rst_valid", data_valid, 0);
        check("rst_stall", cpu_stall, 0);
        rst = 1'b1;
        // 1: idle CPU, data valid from cycle 3
        step();
        view_en = 1'b1; view_addr = 32'h10; cpu_ce = 1'b0;
        #1;
        check("t1_c0_ramce", ram_ce, 0);
        step(); #1;
        check("t1_grant_ce", ram_ce, 1);
        check("t1_grant_addr", ram_addr, 32'h40);
        check("t1_grant_we", ram_we, 0);
        check("t1_grant_sel", ram_sel, 4'hF);
        check("t1_grant_wdata", ram_wdata, 0);
        check("t1_grant_stall", cpu_stall, 0);
        step(); #1;
        check("t1_c2_valid", data_valid, 0);
        check("t1_rdata", cpu_rdata, 32'h1234ABCD);
        step(); #1;
        check("t1_valid", data_valid, 1);
        check("t1_high", data_high, 32'h1234);
        check("t1_low", data_low, 32'hABCD);
        // 2: CPU busy for 5 cycles, read in first idle cycle
        restart(32'h10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            cpu_addr = 32'h100 + 4 * i;
            #1;
            check("t2_pass_addr", ram_addr, 32'h100 + 4 * i);
            check("t2_busy_stall", cpu_stall, 0);
        end
        step();
        cpu_ce = 1'b0;
        #1;
        check("t2_grant_addr", ram_addr, 32'h40);
        check("t2_grant_stall", cpu_stall, 0);
        step(); step(); #1;
        check("t2_valid", data_valid, 1);
        check("t2_data", {data_high, data_low}, 32'h1234ABCD);
        // 3: CPU busy forever, one forced stall 16 cycles into WAIT_SLOT
        cpu_addr = 32'h200;
        restart(32'h10, 1'b1);
        #1;
        stalls = 0;
        first_stall = 0;
        for (int i = 1; i <= 30; i++) begin
            step(); #1;
            if (cpu_stall) begin
                stalls++;
                if (first_stall == 0) first_stall = i;
                check("t3_stall_addr", ram_addr, 32'h40);
            end
            if (i == 19) begin
                check("t3_valid", data_valid, 1);
                check("t3_data", {data_high, data_low}, 32'h1234ABCD);
            end
        end
        check("t3_stall_count", stalls, 1);
        check("t3_stall_cycle", first_stall, 17);
        // 4: CPU write picked up by periodic refresh
        restart(32'h10, 1'b0);
        step(); step(); step();
        cpu_ce = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_sel = 4'hF; cpu_wdata = 32'hDEADBEEF;
        #1;
        check("t4_pre_valid", data_valid, 1);
        check("t4_write_pass", ram_we, 1);
        check("t4_old_high", data_high, 32'h1234);
        step();
        cpu_ce = 1'b0; cpu_we = 1'b0;
        #1;
        n = 0;
        while (n < 11 && {data_high, data_low} != 32'hDEADBEEF) begin
            step(); #1;
            n++;
        end
        check("t4_refresh", {data_high, data_low}, 32'hDEADBEEF);
        check("t4_refresh_valid", data_valid, 1);
        // 5: address change during CAPTURE discards stale word
        restart(32'h10, 1'b0);
        #1;
        step(); #1;
        step();
        view_addr = 32'h20;
        #1;
        check("t5_cap_valid", data_valid, 0);
        step(); #1;
        check("t5_regrant_addr", ram_addr, 32'h80);
        check("t5_no_commit", {data_high, data_low}, 0);
        check("t5_c3_valid", data_valid, 0);
        step(); #1;
        check("t5_c4_valid", data_valid, 0);
        step(); #1;
        check("t5_valid", data_valid, 1);
        check("t5_data", {data_high, data_low}, 32'hCAFEF00D);
        // 6a: view_en dropped in WAIT_SLOT
        step();
        view_addr = 32'h10; cpu_ce = 1'b1; cpu_addr = 32'h300;
        #1;
        step(); #1;
        step(); #1;
        check("t6a_hold_high", data_high, 32'hCAFE);
        check("t6a_wait_valid", data_valid, 0);
        step();
        view_en = 1'b0;
        #1;
        check("t6a_stall", cpu_stall, 0);
        check("t6a_now_addr", ram_addr, 32'h300);
        step(); #1;
        check("t6a_data", {data_high, data_low}, 0);
        check("t6a_valid", data_valid, 0);
        check("t6a_ram_addr", ram_addr, 32'h300);
        check("t6a_ram_ce", ram_ce, 1);
        // 6b: reset pulsed during CAPTURE
        view_en = 1'b1; view_addr = 32'h20; cpu_ce = 1'b0;
        step(); step(); step(); #1;
        check("t6b_pre_valid", data_valid, 1);
        view_addr = 32'h10;
        step(); step();
        rst = 1'b0; cpu_ce = 1'b1; cpu_addr = 32'h304;
        #1;
        check("t6b_data", {data_high, data_low}, 0);
        check("t6b_valid", data_valid, 0);
        check("t6b_stall", cpu_stall, 0);
        check("t6b_ram_addr", ram_addr, 32'h304);
        step();
        rst = 1'b1;
        step(); #1;
        check("t6b_after_addr", ram_addr, 32'h304);
        check("t6b_after_valid", data_valid, 0);
        check("t6b_after_stall", cpu_stall, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/debug_view_port.md
Name: debug_view_port

Overview:
- Responder side of the board-level memory-view interface: accepts view_en/view_addr from the board top and returns the addressed 32-bit data-RAM word as data_high/data_low for the seven-segment display.
- Sits inside openmips_min_sopc between the CPU memory stage and the single-port data RAM.
- Steals idle RAM cycles for its reads. If the CPU starves it, it forces one stall cycle.
- Periodically re-reads the word so the display tracks memory writes made by running code.

Parameters:
- REFRESH_CYCLES, 1000000: clock cycles between automatic re-reads while view_en=1.
- STARVE_LIMIT, 16: consecutive CPU-busy cycles tolerated in WAIT_SLOT before a forced stall.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- view_en  input  1  view request; already debounced, clk domain.
- view_addr  input  32  word index; byte address = {view_addr[29:0],2'b00}.
- data_high  output  16  viewed word [31:16].
- data_low  output  16  viewed word [15:0].
- data_valid  output  1  data_high/data_low correspond to the current latched address.
- cpu_stall  output  1  stall request to pipeline control.
- cpu_ce  input  1  CPU RAM enable.
- cpu_we  input  1  CPU write enable.
- cpu_addr  input  32  CPU byte address.
- cpu_sel  input  4  CPU byte lanes.
- cpu_wdata  input  32  CPU write data.
- cpu_rdata  output  32  read data to CPU (= ram_rdata).
- ram_ce  output  1  RAM enable.
- ram_we  output  1  RAM write enable.
- ram_addr  output  32  RAM byte address.
- ram_sel  output  4  RAM byte lanes.
- ram_wdata  output  32  RAM write data.
- ram_rdata  input  32  RAM read data; synchronous, valid one cycle after address.

Behaviour:
- Reset (rst=0, asynchronous):
  - data_high=0, data_low=0, data_valid=0, cpu_stall=0.
  - State IDLE, latched address=0, refresh counter=0, starve counter=0.
- RAM mux is combinational:
  - View grant: ram_ce=1, ram_we=0, ram_sel=4'hF, ram_addr={addr_q[29:0],2'b00}, ram_wdata=0.
  - Otherwise the cpu_* signals pass through unchanged.
  - cpu_rdata=ram_rdata always.
- Grant rule: the view is granted only in WAIT_SLOT, and only when cpu_ce=0 or the starve counter has reached STARVE_LIMIT.
- States:
  - IDLE: outputs hold. Go to WAIT_SLOT on any of:
    - view_en=1 and view_addr!=addr_q: latch addr_q<=view_addr, clear data_valid.
    - view_en=1 and data_valid=0.
    - view_en=1 and refresh counter reached REFRESH_CYCLES-1: counter clears.
  - WAIT_SLOT:
    - If granted: go to CAPTURE and clear the starve counter.
    - Else: increment the starve counter.
    - Forced grant (counter==STARVE_LIMIT with cpu_ce=1): cpu_stall=1 for exactly that cycle. The view owns the RAM, and the CPU access is discarded and retried after the stall.
  - CAPTURE (one cycle): the CPU owns the RAM.
    - If view_addr==addr_q: data_high<=ram_rdata[31:16], data_low<=ram_rdata[15:0], data_valid<=1, go to IDLE.
    - If view_addr!=addr_q: discard the data, latch the new address, go to WAIT_SLOT.
- Refresh counter:
  - Increments every cycle while view_en=1 and the state is IDLE.
  - Wraps at REFRESH_CYCLES-1.
- view_en=0 at any state, synchronous to clk, overrides all other transitions:
  - Next state IDLE, data_high/data_low<=0, data_valid<=0.
  - addr_q<=0, refresh and starve counters cleared, cpu_stall=0 combinationally.
  - An in-flight read is dropped.
- Address change in WAIT_SLOT: re-latch addr_q; the state is unchanged and the starve counter is kept.
- CPU write and refresh read to the same word:
  - The CPU wins the slot.
  - The refresh issued after the write returns the new value.
- Latency with an idle CPU: the address change is seen in IDLE at cycle 0, WAIT_SLOT grants at cycle 1, and data_valid=1 from cycle 3.
- cpu_stall is never asserted outside a forced grant, and never on two consecutive cycles.

Test Plan:
1. Reset; preload RAM word 0x10 with 0x1234ABCD; view_en=1, view_addr=0x10, cpu_ce=0 -> data_high=0x1234, data_low=0xABCD, data_valid=1 at cycle 3; cpu_stall stays 0.
2. Same as 1 with cpu_ce=1 for 5 cycles, then 0 -> view read happens in the first idle cycle; no stall; CPU addresses reach the RAM untouched during the busy cycles.
3. cpu_ce held 1 forever with STARVE_LIMIT=16 -> exactly one cpu_stall pulse, 16 cycles after entering WAIT_SLOT; correct data captured next cycle; no further stalls until the next request.
4. After valid data, CPU writes 0xDEADBEEF to word 0x10; REFRESH_CYCLES=8 -> data_high/data_low become 0xDEAD/0xBEEF within 8+3 cycles.
5. Change view_addr 0x10->0x20 during CAPTURE -> the old data is not committed; data_valid stays 0 until word 0x20 is read.
6. Drop view_en mid-WAIT_SLOT, and separately pulse rst low mid-CAPTURE -> outputs 0, data_valid 0, cpu_stall 0, RAM fully owned by the CPU next cycle.
